// File: rtl/i4001_pkg.sv
// Shared constants for the i4001 ROM slice: bus-cycle phase encoding and I/O opcodes.
package i4001_pkg;

   localparam int unsigned NIB_W  = 4;
   localparam int unsigned ADDR_W = 8;

   typedef enum logic [2:0] {
      A1 = 3'd0,
      A2 = 3'd1,
      A3 = 3'd2,
      M1 = 3'd3,
      M2 = 3'd4,
      X1 = 3'd5,
      X2 = 3'd6,
      X3 = 3'd7
   } phase_t;

   localparam logic [NIB_W-1:0] OPA_WRR = 4'h2;
   localparam logic [NIB_W-1:0] OPA_RDR = 4'hA;

endpackage

// File: rtl/i4001_rom_phase_tracker.sv
// Turns the two-phase clock enables into phase-start/latch pulses and tracks the
// current bus phase, realigning to A1 after a phase in which sync was latched.
module rom_phase_tracker
   import i4001_pkg::*;
(
   input  logic       sysclk,
   input  logic       poc,
   input  logic       clk1,
   input  logic       clk2,
   input  logic       sync,
   output logic [2:0] phase,
   output logic       phase_start,
   output logic       latch
);

   logic   clk1_q;
   logic   clk2_q;
   logic   sync_seen_q;
   phase_t phase_q;

   assign phase_start = clk1 & ~clk1_q;
   assign latch       = clk2 & ~clk2_q;
   assign phase       = phase_q;

   // A missing sync just lets the counter free-run and wrap.
   always_ff @(posedge sysclk) begin
      if (poc) begin
         clk1_q      <= 1'b0;
         clk2_q      <= 1'b0;
         sync_seen_q <= 1'b0;
         phase_q     <= X3;
      end else begin
         clk1_q <= clk1;
         clk2_q <= clk2;
         if (phase_start) begin
            phase_q     <= sync_seen_q ? A1 : phase_t'(3'(phase_q + 3'd1));
            sync_seen_q <= 1'b0;
         end else if (latch && sync) begin
            sync_seen_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/i4001_rom.sv
// 4001-style ROM/I/O chip: captures the fetch address, drives the ROM word in M1/M2
// when selected, and services SRC-selected WRR/RDR port accesses in X2.
module i4001_rom
   import i4001_pkg::*;
#(
   parameter logic [3:0] CHIP_ID     = 4'h0,
   parameter logic [3:0] IO_OUT_MASK = 4'hF
) (
   input  logic       sysclk,
   input  logic       poc,
   input  logic       clk1,
   input  logic       clk2,
   input  logic       sync,
   input  logic       cmrom,
   input  logic [3:0] data_in,
   output logic [3:0] data_out,
   output logic       data_oe,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_data,
   input  logic [3:0] io_in,
   output logic [3:0] io_out
);

   logic [2:0] phase;
   logic       phase_start;
   logic       latch;
   phase_t     ph;

   logic [ADDR_W-1:0] addr_q,       addr_d;
   logic              selected_q,   selected_d;
   logic              src_sel_q,    src_sel_d;
   logic              io_pending_q, io_pending_d;
   logic [NIB_W-1:0]  opa_q,        opa_d;
   logic [NIB_W-1:0]  io_out_q,     io_out_d;

   rom_phase_tracker u_phase (
      .sysclk      (sysclk),
      .poc         (poc),
      .clk1        (clk1),
      .clk2        (clk2),
      .sync        (sync),
      .phase       (phase),
      .phase_start (phase_start),
      .latch       (latch)
   );

   assign ph = phase_t'(phase);

   // Bus-latch actions, keyed on the phase the latch point falls in.
   always_comb begin
      addr_d       = addr_q;
      selected_d   = selected_q;
      src_sel_d    = src_sel_q;
      io_pending_d = io_pending_q;
      opa_d        = opa_q;
      io_out_d     = io_out_q;

      if (phase_start && ph == X2) begin
         io_pending_d = 1'b0;
      end

      if (latch) begin
         case (ph)
            A1: addr_d[3:0] = data_in;
            A2: addr_d[7:4] = data_in;
            A3: selected_d  = (data_in == CHIP_ID);
            M2: begin
               if (cmrom) begin
                  io_pending_d = 1'b1;
                  opa_d        = data_in;
               end else begin
                  io_pending_d = 1'b0;
               end
            end
            X2: begin
               // A pending I/O op owns this X2, so cmrom is not taken as SRC.
               if (io_pending_q) begin
                  if (opa_q == OPA_WRR && src_sel_q) begin
                     io_out_d = data_in & IO_OUT_MASK;
                  end
               end else if (cmrom) begin
                  src_sel_d = (data_in == CHIP_ID);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sysclk) begin
      if (poc) begin
         addr_q       <= '0;
         selected_q   <= 1'b0;
         src_sel_q    <= 1'b0;
         io_pending_q <= 1'b0;
         opa_q        <= '0;
         io_out_q     <= '0;
      end else begin
         addr_q       <= addr_d;
         selected_q   <= selected_d;
         src_sel_q    <= src_sel_d;
         io_pending_q <= io_pending_d;
         opa_q        <= opa_d;
         io_out_q     <= io_out_d;
      end
   end

   assign rom_addr = addr_q;
   assign io_out   = io_out_q;

   // Bus drive decoded from registered phase/state so it covers each whole phase.
   always_comb begin
      data_oe  = 1'b0;
      data_out = '0;
      case (ph)
         M1: begin
            if (selected_q) begin
               data_oe  = 1'b1;
               data_out = rom_data[7:4];
            end
         end
         M2: begin
            if (selected_q) begin
               data_oe  = 1'b1;
               data_out = rom_data[3:0];
            end
         end
         X2: begin
            if (io_pending_q && opa_q == OPA_RDR && src_sel_q) begin
               data_oe  = 1'b1;
               data_out = (io_in & ~IO_OUT_MASK) | (io_out_q & IO_OUT_MASK);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_i4001_rom.sv
// Directed plus randomized bench for i4001_rom against a phase-level behavioural model.
module tb_i4001_rom;

   localparam logic [3:0] CHIP = 4'h3;
   localparam logic [3:0] MASK = 4'b1100;

   logic       sysclk = 1'b0;
   logic       poc, clk1, clk2, sync, cmrom;
   logic [3:0] data_in, data_out, io_in, io_out;
   logic       data_oe;
   logic [7:0] rom_addr, rom_data;

   logic [7:0] rom_mem [256];

   int checks   = 0;
   int failures = 0;

   // Model state, kept as bus-level facts rather than RTL registers
   int         m_phase;
   bit         m_c1p, m_c2p, m_syn, m_sel, m_src, m_pend;
   logic [3:0] m_opa, m_io;
   logic [7:0] m_addr;
   bit         oe_seen;

   i4001_rom #(.CHIP_ID(CHIP), .IO_OUT_MASK(MASK)) dut (
      .sysclk   (sysclk),
      .poc      (poc),
      .clk1     (clk1),
      .clk2     (clk2),
      .sync     (sync),
      .cmrom    (cmrom),
      .data_in  (data_in),
      .data_out (data_out),
      .data_oe  (data_oe),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .io_in    (io_in),
      .io_out   (io_out)
   );

   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit ps, lt;
      int nxt;
      if (poc) begin
         m_phase = 7; m_addr = 8'h00; m_sel = 0; m_src = 0; m_pend = 0;
         m_opa = 4'h0; m_io = 4'h0; m_c1p = 0; m_c2p = 0; m_syn = 0;
      end else begin
         ps = clk1 && !m_c1p;
         lt = clk2 && !m_c2p;
         m_c1p = clk1;
         m_c2p = clk2;
         if (ps) begin
            nxt = m_syn ? 0 : (m_phase + 1) % 8;
            m_syn = 0;
            if (nxt == 7) m_pend = 0;
            m_phase = nxt;
         end
         if (lt) begin
            if (sync) m_syn = 1;
            case (m_phase)
               0: m_addr[3:0] = data_in;
               1: m_addr[7:4] = data_in;
               2: m_sel = (data_in == CHIP);
               4: if (cmrom) begin m_pend = 1; m_opa = data_in; end else m_pend = 0;
               6: if (m_pend) begin
                     if (m_opa == 4'h2 && m_src) m_io = data_in & MASK;
                  end else if (cmrom) m_src = (data_in == CHIP);
               default: ;
            endcase
         end
      end
   endtask

   task automatic check_outputs();
      logic       e_oe;
      logic [3:0] e_out;
      e_oe = 1'b0;
      e_out = 4'h0;
      if (m_phase == 3 && m_sel) begin e_oe = 1'b1; e_out = rom_data[7:4]; end
      if (m_phase == 4 && m_sel) begin e_oe = 1'b1; e_out = rom_data[3:0]; end
      if (m_phase == 6 && m_pend && m_opa == 4'hA && m_src) begin
         e_oe = 1'b1;
         e_out = (io_in & ~MASK) | (m_io & MASK);
      end
      if (data_oe === 1'b1) oe_seen = 1;
      chk("data_oe",  8'(data_oe),  8'(e_oe));
      chk("data_out", 8'(data_out), 8'(e_out));
      chk("rom_addr", rom_addr,     m_addr);
      chk("io_out",   8'(io_out),   8'(m_io));
   endtask

   task automatic tick(input logic c1, input logic c2);
      @(negedge sysclk);
      clk1 = c1;
      clk2 = c2;
      rom_data = rom_mem[m_addr];
      @(posedge sysclk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic run_phase(input logic [3:0] nib, input logic cm, input logic syn);
      data_in = nib;
      cmrom   = cm;
      sync    = syn;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
   endtask

   task automatic run_cycle(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                            input logic cm_m2, input logic [3:0] m2n,
                            input logic cm_x2, input logic [3:0] x2n);
      run_phase(a1, 1'b0, 1'b0);
      run_phase(a2, 1'b0, 1'b0);
      run_phase(a3, 1'b0, 1'b0);
      run_phase(4'($urandom), 1'b0, 1'b0);
      run_phase(m2n, cm_m2, 1'b0);
      run_phase(4'($urandom), 1'b0, 1'b0);
      run_phase(x2n, cm_x2, 1'b0);
      run_phase(4'($urandom), 1'b0, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
      rom_mem[8'hA5] = 8'hC7;
      poc = 1'b1; clk1 = 1'b0; clk2 = 1'b0; sync = 1'b0; cmrom = 1'b0;
      data_in = 4'h0; io_in = 4'h0; rom_data = 8'h00;

      // Reset values
      repeat (3) tick(1'b0, 1'b0);
      chk("rst_rom_addr", rom_addr, 8'h00);
      chk("rst_data_oe",  8'(data_oe), 8'h00);
      chk("rst_io_out",   8'(io_out),  8'h00);
      poc = 1'b0;

      // Selected fetch of word C7 at A5
      run_phase(4'h5, 1'b0, 1'b0);
      run_phase(4'hA, 1'b0, 1'b0);
      run_phase(4'h3, 1'b0, 1'b0);
      chk("fetch_addr", rom_addr, 8'hA5);
      run_phase(4'h0, 1'b0, 1'b0);
      chk("fetch_m1_oe", 8'(data_oe), 8'h01);
      chk("fetch_m1",    8'(data_out), 8'h0C);
      run_phase(4'h0, 1'b0, 1'b0);
      chk("fetch_m2_oe", 8'(data_oe), 8'h01);
      chk("fetch_m2",    8'(data_out), 8'h07);
      run_phase(4'h0, 1'b0, 1'b0);
      run_phase(4'h0, 1'b0, 1'b0);
      chk("fetch_x2_oe", 8'(data_oe), 8'h00);
      run_phase(4'h0, 1'b0, 1'b1);

      // Unselected fetch never drives the bus
      oe_seen = 0;
      run_cycle(4'h5, 4'hA, 4'h2, 1'b0, 4'h0, 1'b0, 4'h0);
      chk("unsel_oe_seen", 8'(oe_seen), 8'h00);

      // SRC selects this chip, then WRR writes the output bits only
      run_cycle(4'h1, 4'h2, 4'h0, 1'b0, 4'h0, 1'b1, 4'h3);
      run_cycle(4'h1, 4'h2, 4'h0, 1'b1, 4'h2, 1'b0, 4'b1010);
      chk("wrr_io_out", 8'(io_out), 8'b0000_1000);

      // RDR merges input pins with output latches
      io_in = 4'b0101;
      run_phase(4'h1, 1'b0, 1'b0);
      run_phase(4'h2, 1'b0, 1'b0);
      run_phase(4'h0, 1'b0, 1'b0);
      run_phase(4'h0, 1'b0, 1'b0);
      run_phase(4'hA, 1'b1, 1'b0);
      run_phase(4'h0, 1'b0, 1'b0);
      run_phase(4'h0, 1'b0, 1'b0);
      chk("rdr_oe",  8'(data_oe),  8'h01);
      chk("rdr_out", 8'(data_out), 8'b0000_1001);
      run_phase(4'h0, 1'b0, 1'b1);

      // Sync withheld for two cycles, then given off-alignment
      for (int i = 0; i < 16; i++) run_phase(4'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)  run_phase(4'($urandom), 1'b0, 1'b0);
      run_phase(4'($urandom), 1'b0, 1'b1);
      run_phase(4'h6, 1'b0, 1'b0);
      run_phase(4'h9, 1'b0, 1'b0);
      chk("resync_addr", rom_addr, 8'h96);
      run_phase(4'h3, 1'b0, 1'b0);
      run_phase(4'h0, 1'b0, 1'b0);
      chk("resync_m1_oe", 8'(data_oe), 8'h01);
      run_phase(4'h0, 1'b0, 1'b0);
      run_phase(4'h0, 1'b0, 1'b0);
      run_phase(4'h0, 1'b0, 1'b0);
      run_phase(4'h0, 1'b0, 1'b1);

      // Randomized bus cycles
      for (int n = 0; n < 24; n++) begin
         io_in = 4'($urandom);
         run_cycle(4'($urandom), 4'($urandom),
                   ($urandom_range(0, 1) == 0) ? CHIP : 4'($urandom),
                   1'($urandom), ($urandom_range(0, 1) == 0) ? 4'h2 : 4'($urandom),
                   1'($urandom), ($urandom_range(0, 2) == 0) ? CHIP : 4'($urandom));
      end

      // Reset in M1 of a selected fetch drops everything on the next edge
      run_phase(4'h5, 1'b0, 1'b0);
      run_phase(4'hA, 1'b0, 1'b0);
      run_phase(4'h3, 1'b0, 1'b0);
      data_in = 4'h0;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("midm1_oe_before", 8'(data_oe), 8'h01);
      poc = 1'b1;
      tick(1'b0, 1'b0);
      chk("midm1_rst_oe",   8'(data_oe),  8'h00);
      chk("midm1_rst_out",  8'(data_out), 8'h00);
      chk("midm1_rst_addr", rom_addr,     8'h00);
      chk("midm1_rst_io",   8'(io_out),   8'h00);
      tick(1'b0, 1'b0);
      poc = 1'b0;
      run_cycle(4'h7, 4'h4, 4'h3, 1'b0, 4'h0, 1'b0, 4'h0);
      chk("post_rst_addr", rom_addr, 8'h47);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
